// File: rtl/csa_accum_ctrl.sv
// ---------------------------------------------------------------------------
// csa_accum_ctrl
//
// Multi-operand accumulator controller built around a 3:2 carry-save
// compressor. A framed stream of unsigned operands arrives over a valid/ready
// handshake. The running total is kept in redundant sum/carry form, with one
// compressor pass per operand. After the last operand, a single carry-propagate
// cycle resolves the total. The binary result is then presented together with
// an exact overflow flag.
//
// Optional feature (compile-time macro CSA_ACC_SAT_EN):
//   defined   - an overflowing frame reports out_sum = all ones (saturation)
//   undefined - out_sum is the total modulo 2^ACC_W; no saturation logic
//
// Parameters:
//   N      operand width in bits
//   ACC_W  accumulator / result width in bits (must be >= N)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort back to idle (highest priority)
//   in_valid   operand valid
//   in_ready   block can accept an operand (high in idle/accumulate)
//   in_data    unsigned operand
//   in_last    in_data is the final operand of the frame
//   out_valid  result available, held until consumed
//   out_ready  consumer accepts the result
//   out_sum    frame total (wrapped, or saturated with CSA_ACC_SAT_EN)
//   out_ovf    true frame total >= 2^ACC_W
// ---------------------------------------------------------------------------
module csa_accum_ctrl #(
    parameter int unsigned N     = 8,
    parameter int unsigned ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StResolve,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [ACC_W-1:0] carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_valid_q, out_valid_d;

    // Operand zero-extended to accumulator width.
    logic [ACC_W-1:0] x;
    assign x = ACC_W'(in_data);

    // 3:2 compressor against the redundant running total.
    logic [ACC_W-1:0] csa_sum;
    logic [ACC_W-1:0] csa_maj;
    logic [ACC_W-1:0] csa_carry;

    always_comb begin
        csa_sum   = sum_q ^ carry_q ^ x;
        csa_maj   = (sum_q & carry_q) | (sum_q & x) | (carry_q & x);
        // Majority bits carry into the next position. The MSB majority bit
        // is shifted out here and accounted for in the overflow flag instead.
        csa_carry = csa_maj << 1;
    end

    // Carry-propagate resolve. The extra bit is the final carry-out.
    logic [ACC_W:0] resolve_full;
    logic           resolve_cout;
    logic           resolve_ovf;

    always_comb begin
        resolve_full = {1'b0, sum_q} + {1'b0, carry_q};
        resolve_cout = resolve_full[ACC_W];
        resolve_ovf  = ovf_q | resolve_cout;
    end

    // in_ready is forced low while reset is asserted. From the first cycle
    // after release, it follows the state.
    logic ready_state;
    logic beat_acc;
    logic res_acc;

    always_comb begin
        ready_state = (state_q == StIdle) || (state_q == StAccum);
        in_ready    = rst_n & ready_state;
        // A beat that coincides with clr is dropped even though in_ready is high.
        beat_acc    = in_valid & in_ready & ~clr;
        res_acc     = out_valid_q & out_ready;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        if (clr) begin
            // Abort: clear the accumulator. The previous result values stay
            // on out_sum/out_ovf, but out_valid drops.
            state_d     = StIdle;
            sum_d       = '0;
            carry_d     = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (beat_acc) begin
                        // First beat: equivalent to compressing against zeros.
                        sum_d   = x;
                        carry_d = '0;
                        ovf_d   = 1'b0;
                        state_d = in_last ? StResolve : StAccum;
                    end
                end
                StAccum: begin
                    if (beat_acc) begin
                        sum_d   = csa_sum;
                        carry_d = csa_carry;
                        ovf_d   = ovf_q | csa_maj[ACC_W-1];
                        state_d = in_last ? StResolve : StAccum;
                    end
                end
                StResolve: begin
`ifdef CSA_ACC_SAT_EN
                    out_sum_d = resolve_ovf ? {ACC_W{1'b1}} : resolve_full[ACC_W-1:0];
`else
                    out_sum_d = resolve_full[ACC_W-1:0];
`endif
                    out_ovf_d   = resolve_ovf;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
                StDone: begin
                    if (res_acc) begin
                        out_valid_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sum_q       <= '0;
            carry_q     <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule
